// File: rtl/fifo_pkg.sv
// Shared word type, width and read-stream state encoding for the FIFO read-side blocks.
package fifo_pkg;

    localparam int FIFO_DATA_W = 8;

    typedef logic [FIFO_DATA_W-1:0] data_t;

    typedef enum logic [0:0] {
        RDS_RUN   = 1'b0,
        RDS_FLUSH = 1'b1
    } rds_state_e;

    // Counter width for a modulo-n counter; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_rd_skid_buf.sv
// Two-entry {data, last} buffer; head is always slot 0 and is registered.
// Latency: a write is visible at the head the cycle after it is accepted.
// Backpressure: none internally; the caller keeps writes within the free space.
module fifo_rd_skid_buf
    import fifo_pkg::*;
#(
    parameter int DATA_W = FIFO_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              wr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_last,
    input  logic              rd,
    output logic [1:0]        occ,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last
);

    logic [DATA_W-1:0] dat0;
    logic [DATA_W-1:0] dat1;
    logic              lst0;
    logic              lst1;
    logic              wr_ok;
    logic              rd_ok;

    // A write into a full buffer is only legal when the head leaves the same cycle.
    assign wr_ok = wr && ((occ != 2'd2) || rd);
    assign rd_ok = rd && (occ != 2'd0);

    assign rd_data = dat0;
    assign rd_last = lst0;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            occ  <= 2'd0;
            dat0 <= '0;
            lst0 <= 1'b0;
            dat1 <= '0;
            lst1 <= 1'b0;
        end else begin
            case ({wr_ok, rd_ok})
                2'b11: begin
                    if (occ == 2'd1) begin
                        dat0 <= wr_data;
                        lst0 <= wr_last;
                    end else begin
                        dat0 <= dat1;
                        lst0 <= lst1;
                        dat1 <= wr_data;
                        lst1 <= wr_last;
                    end
                end
                2'b01: begin
                    dat0 <= dat1;
                    lst0 <= lst1;
                    occ  <= occ - 2'd1;
                end
                2'b10: begin
                    if (occ == 2'd0) begin
                        dat0 <= wr_data;
                        lst0 <= wr_last;
                    end else begin
                        dat1 <= wr_data;
                        lst1 <= wr_last;
                    end
                    occ <= occ + 2'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fifo_rd_stream.sv
// FIFO read-port consumer: pops, absorbs RAM read latency, frames packets; FIFO_RD_STREAM_CNT_EN adds pkt_cnt.
// Latency: pop at t, word captured end of t+1, m_valid at t+2 when the buffer was empty.
// Backpressure: m_ready low caps buffered plus in-flight words at 2; full rate with m_ready high.
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int DATA_W  = FIFO_DATA_W,
    parameter int PKT_LEN = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_pop,
    input  logic              flush,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              busy
`ifdef FIFO_RD_STREAM_CNT_EN
    ,
    output logic [15:0]       pkt_cnt
`endif
);

    localparam int               CNT_W     = cnt_width(PKT_LEN);
    localparam logic [CNT_W-1:0] WCNT_LAST = CNT_W'(PKT_LEN - 1);

    rds_state_e       state;
    logic             infl;
    logic [CNT_W-1:0] wcnt;
    logic [1:0]       occ;
    logic             running;
    logic             deq;
    logic             buf_wr;
    logic             buf_clr;
    logic             wr_last;
    logic [2:0]       credit_used;

    assign running = (state == RDS_RUN);
    assign busy    = (state == RDS_FLUSH);
    assign m_valid = running && (occ != 2'd0);
    assign deq     = m_valid && m_ready;

    // A word leaving this cycle frees its slot in time for a new pop.
    assign credit_used = {1'b0, occ} + {2'b00, infl};
    assign fifo_pop    = running && !rst && !fifo_empty && !flush &&
                         (credit_used < (3'd2 + {2'b00, deq}));

    // The returning word is dropped on the flush cycle and while flushing.
    assign buf_clr = running && flush;
    assign buf_wr  = infl && running && !flush;
    assign wr_last = (wcnt == WCNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RDS_RUN;
            infl  <= 1'b0;
            wcnt  <= '0;
        end else begin
            infl <= fifo_pop;
            case (state)
                RDS_RUN: begin
                    if (flush) begin
                        state <= RDS_FLUSH;
                        wcnt  <= '0;
                    end else if (buf_wr) begin
                        wcnt <= wr_last ? '0 : wcnt + CNT_W'(1);
                    end
                end
                RDS_FLUSH: begin
                    if (!infl) begin
                        state <= RDS_RUN;
                    end
                end
                default: state <= RDS_RUN;
            endcase
        end
    end

    fifo_rd_skid_buf #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .clr     (buf_clr),
        .wr      (buf_wr),
        .wr_data (fifo_data),
        .wr_last (wr_last),
        .rd      (deq),
        .occ     (occ),
        .rd_data (m_data),
        .rd_last (m_last)
    );

`ifdef FIFO_RD_STREAM_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_cnt <= 16'd0;
        end else if (deq && m_last) begin
            pkt_cnt <= pkt_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Scoreboard bench: a queue-based FIFO source feeds the DUT, popped words are expected in order at the output.
module tb_fifo_rd_stream;

    localparam int DATA_W = 8;
`ifdef FIFO_RD_STREAM_CNT_EN
    localparam int PKT_LEN = 4;
`else
    localparam int PKT_LEN = 16;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_data;
    logic              fifo_pop;
    logic              flush;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic              m_last;
    logic              busy;
`ifdef FIFO_RD_STREAM_CNT_EN
    logic [15:0]       pkt_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int pops_total = 0;
    int dlv_total = 0;
    int dcnt = 0;
    int lat_cyc = -1;
    int pkts_model = 0;

    logic [DATA_W-1:0] src_q[$];
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] pend_dat;
    logic              pend_vld = 1'b0;
    logic [DATA_W-1:0] exp_w;
    logic              prev_stall = 1'b0;
    logic [DATA_W-1:0] prev_dat;
    logic              prev_last;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fifo_rd_stream #(
        .DATA_W  (DATA_W),
        .PKT_LEN (PKT_LEN)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_pop   (fifo_pop),
        .flush      (flush),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .busy       (busy)
`ifdef FIFO_RD_STREAM_CNT_EN
        ,
        .pkt_cnt    (pkt_cnt)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Registered-read FIFO: data for a pop appears the following cycle; empty reflects remaining words.
    always @(negedge clk) begin
        #1;
        fifo_data  = pend_vld ? pend_dat : DATA_W'($urandom);
        fifo_empty = (src_q.size() == 0);
        #1;
        pend_vld = 1'b0;
        if (rst || flush || fifo_empty || busy) begin
            check("pop_gated", 32'(fifo_pop), 32'd0);
        end else if (fifo_pop) begin
            pend_dat = src_q.pop_front();
            pend_vld = 1'b1;
            if (exp_q.size() == 0) lat_cyc = cyc + 2;
            exp_q.push_back(pend_dat);
            pops_total++;
        end
    end

    // Monitor: every handshake must deliver the oldest popped, undiscarded word.
    always @(negedge clk) begin
        #3;
        if (rst) begin
            exp_q.delete();
            dcnt       = 0;
            lat_cyc    = -1;
            prev_stall = 1'b0;
            pkts_model = 0;
        end else begin
`ifdef FIFO_RD_STREAM_CNT_EN
            check("pkt_cnt", 32'(pkt_cnt), 32'(pkts_model));
`endif
            if (cyc == lat_cyc) check("latency_valid", 32'(m_valid), 32'd1);
            if (prev_stall) begin
                check("hold_valid", 32'(m_valid), 32'd1);
                check("hold_data", 32'(m_data), 32'(prev_dat));
                check("hold_last", 32'(m_last), 32'(prev_last));
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL spurious_word: got 0x%0h, required no word (cycle %0d)", m_data, cyc);
                end else begin
                    exp_w = exp_q.pop_front();
                    check("data", 32'(m_data), 32'(exp_w));
                    check("last", 32'(m_last), 32'((dcnt % PKT_LEN) == PKT_LEN - 1));
                    if ((dcnt % PKT_LEN) == PKT_LEN - 1) pkts_model++;
                    dcnt++;
                    dlv_total++;
                end
            end
            if (flush && !busy) begin
                exp_q.delete();
                dcnt    = 0;
                lat_cyc = -1;
            end
            check("credit", 32'(exp_q.size() > 2), 32'd0);
            prev_stall = m_valid && !m_ready && !flush;
            prev_dat   = m_data;
            prev_last  = m_last;
        end
    end

    task automatic tick();
        @(negedge clk);
        #4;
    endtask

    task automatic push_words(input int n);
        for (int i = 0; i < n; i++) src_q.push_back(DATA_W'($urandom));
    endtask

    task automatic wait_dlv(input int target, input int budget);
        int n = 0;
        while (dlv_total < target && n < budget) begin
            tick();
            n++;
        end
        check("deliver_count", 32'(dlv_total), 32'(target));
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst = 1'b1;
        tick();
        @(negedge clk);
        rst = 1'b0;
        #4;
    endtask

    initial begin
        int base;
        int c0;
        int p0;
        int n;

        rst        = 1'b1;
        flush      = 1'b0;
        m_ready    = 1'b0;
        fifo_empty = 1'b1;
        fifo_data  = '0;

        // Reset with 5 words waiting.
        push_words(5);
        m_ready = 1'b1;
        repeat (3) tick();
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_data", 32'(m_data), 32'd0);
        check("rst_m_last", 32'(m_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_pop", 32'(fifo_pop), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #4;
        check("first_pop", 32'(fifo_pop), 32'd1);
        wait_dlv(5, 30);
        repeat (3) tick();
        check("drained_valid", 32'(m_valid), 32'd0);

        // 40 words at full rate.
        reset_pulse();
        base = dlv_total;
        push_words(40);
        wait_dlv(base + 1, 20);
        c0 = cyc;
        wait_dlv(base + 40, 200);
        check("no_bubbles", 32'(cyc - c0), 32'd39);

        // Back-pressure.
        repeat (3) tick();
        @(negedge clk);
        m_ready = 1'b0;
        p0 = pops_total;
        base = dlv_total;
        push_words(8);
        repeat (10) tick();
        check("bp_pops", 32'(pops_total - p0), 32'd2);
        @(negedge clk);
        m_ready = 1'b1;
        wait_dlv(base + 8, 60);

        // Flush while a word is in flight.
        repeat (3) tick();
        p0 = pops_total;
        base = dlv_total;
        push_words(1);
        n = 0;
        while (pops_total == p0 && n < 10) begin
            tick();
            n++;
        end
        check("flush_setup_pop", 32'(pops_total - p0), 32'd1);
        @(negedge clk);
        flush = 1'b1;
        #4;
        check("busy_before", 32'(busy), 32'd0);
        @(negedge clk);
        flush = 1'b0;
        #4;
        check("busy_flush", 32'(busy), 32'd1);
        tick();
        check("busy_after", 32'(busy), 32'd0);
        repeat (3) tick();
        check("flushed_word_dropped", 32'(dlv_total), 32'(base));
        push_words(20);
        wait_dlv(base + 20, 80);

        // Randomised traffic with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            m_ready = ($urandom_range(0, 3) != 0);
            flush   = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 2) != 0 && src_q.size() < 6) push_words(1);
        end
        @(negedge clk);
        flush   = 1'b0;
        m_ready = 1'b1;
        n = 0;
        while ((src_q.size() != 0 || exp_q.size() != 0) && n < 100) begin
            tick();
            n++;
        end
        check("drain_src", 32'(src_q.size()), 32'd0);
        check("drain_exp", 32'(exp_q.size()), 32'd0);

        // Reset with a word buffered and one in flight.
        @(negedge clk);
        m_ready = 1'b0;
        p0 = pops_total;
        push_words(5);
        n = 0;
        while (pops_total < p0 + 2 && n < 10) begin
            tick();
            n++;
        end
        check("rst_mid_setup", 32'(pops_total - p0), 32'd2);
        @(negedge clk);
        rst = 1'b1;
        #4;
        @(negedge clk);
        #4;
        check("rst_mid_valid", 32'(m_valid), 32'd0);
        check("rst_mid_pop", 32'(fifo_pop), 32'd0);
        @(negedge clk);
        rst     = 1'b0;
        m_ready = 1'b1;
        base = dlv_total;
        wait_dlv(base + 3, 30);
        repeat (4) tick();
        check("rst_mid_leftover", 32'(dlv_total - base), 32'd3);

`ifdef FIFO_RD_STREAM_CNT_EN
        reset_pulse();
        base = dlv_total;
        push_words(12);
        wait_dlv(base + 12, 60);
        tick();
        check("pkt_cnt_12", 32'(pkt_cnt), 32'd3);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        repeat (3) tick();
        check("pkt_cnt_flush", 32'(pkt_cnt), 32'd3);
`endif

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

endmodule
